// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder
// Purpose  : SHA-256 message padder. Buffers one 512-bit block, applies
//            0x80 / zero fill / 64-bit length, streams 64 bytes to the core.
// Revision : 1.0
// ============================================================================
module sha256_padder #(
    parameter int BYTE_CNT_W = 61
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       core_busy,
    output logic [7:0] out_data,
    output logic       out_write_enable,
    output logic       out_first_block,
    output logic       out_last_block,
    output logic       msg_done
);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_PAD     = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [7:0]            r_buf [0:63];
    logic [5:0]            r_idx;
    logic [5:0]            r_pad_ptr;
    logic [5:0]            r_send_cnt;
    logic                  r_need_80;
    logic                  r_final;
    logic                  r_pend_pad;
    logic                  r_first;
    logic                  r_sending;
    logic [BYTE_CNT_W-1:0] r_msg_cnt;

    logic [7:0]            r_out_data;
    logic                  r_we;
    logic                  r_first_o;
    logic                  r_last_o;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_emit;
    logic                  w_send_end;
    logic                  w_pad_len;
    logic                  w_pad_wrap;
    logic                  w_wait_done;
    logic                  w_buf_we;
    logic [5:0]            w_buf_addr;
    logic [7:0]            w_buf_wdata;
    logic [63:0]           w_bit_len;

    assign w_bit_len        = 64'({r_msg_cnt, 3'b000});
    assign in_ready         = (r_state == S_FILL);
    assign out_data         = r_out_data;
    assign out_write_enable = r_we;
    assign out_first_block  = r_first_o;
    assign out_last_block   = r_last_o;
    assign msg_done         = r_done;

    always_comb begin
        w_accept    = in_valid && (r_state == S_FILL);
        w_full      = w_accept && (r_idx == 6'd63);
        w_emit      = (r_state == S_SEND) && (r_sending || !core_busy);
        w_send_end  = w_emit && (r_send_cnt == 6'd63);
        // Length goes in only once the 0x80 marker is already in place
        w_pad_len   = (r_state == S_PAD) && !r_need_80 && (r_pad_ptr == 6'd56);
        w_pad_wrap  = (r_state == S_PAD) && !w_pad_len && (r_pad_ptr == 6'd63);
        w_wait_done = (r_state == S_WAIT_LO) && !core_busy;

        w_buf_we    = w_accept || ((r_state == S_PAD) && !w_pad_len);
        w_buf_addr  = w_accept ? r_idx : r_pad_ptr;
        w_buf_wdata = w_accept ? in_data : (r_need_80 ? 8'h80 : 8'h00);

        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept && in_last) begin
                    w_state_nxt = w_full ? S_SEND : S_PAD;
                end else if (w_full) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_PAD: begin
                if (w_pad_len || w_pad_wrap) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_send_end) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (core_busy) begin
                    w_state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (w_wait_done) begin
                    if (r_final) begin
                        w_state_nxt = S_FILL;
                    end else if (r_pend_pad) begin
                        w_state_nxt = S_PAD;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Block buffer carries no reset: its contents are always rewritten before use
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= w_buf_wdata;
        end
        if (w_pad_len) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[6'(56 + k)] <= w_bit_len[8*(7-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= 6'd0;
            r_pad_ptr  <= 6'd0;
            r_send_cnt <= 6'd0;
            r_need_80  <= 1'b0;
            r_final    <= 1'b0;
            r_pend_pad <= 1'b0;
            r_first    <= 1'b1;
            r_sending  <= 1'b0;
            r_msg_cnt  <= '0;
            r_out_data <= 8'h00;
            r_we       <= 1'b0;
            r_first_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_first_o <= 1'b0;
            r_last_o  <= 1'b0;
            r_done    <= 1'b0;

            if (w_accept) begin
                r_idx     <= r_idx + 6'd1;
                r_msg_cnt <= r_msg_cnt + 1'b1;
                if (in_last) begin
                    // A full last block wraps the pointer to 0 and defers padding
                    r_need_80  <= 1'b1;
                    r_pad_ptr  <= r_idx + 6'd1;
                    r_pend_pad <= w_full;
                end
            end

            if (r_state == S_PAD) begin
                if (w_pad_len) begin
                    r_final <= 1'b1;
                end else begin
                    r_pad_ptr <= r_pad_ptr + 6'd1;
                    r_need_80 <= 1'b0;
                    if (w_pad_wrap) begin
                        r_pend_pad <= 1'b1;
                    end
                end
            end

            if (w_emit) begin
                r_out_data <= r_buf[r_send_cnt];
                r_we       <= 1'b1;
                r_first_o  <= (r_send_cnt == 6'd0) && r_first;
                r_last_o   <= (r_send_cnt == 6'd0) && r_final;
                r_send_cnt <= r_send_cnt + 6'd1;
                r_sending  <= !w_send_end;
                if (w_send_end) begin
                    r_first <= 1'b0;
                end
            end

            if (w_wait_done) begin
                r_idx      <= 6'd0;
                r_pend_pad <= 1'b0;
                if (r_final) begin
                    r_done    <= 1'b1;
                    r_final   <= 1'b0;
                    r_first   <= 1'b1;
                    r_msg_cnt <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_padder
// Purpose  : Directed self-checking bench for sha256_padder with a simple
//            core model that pulses busy after each received block.
// Revision : 1.0
// ============================================================================
module tb_sha256_padder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       core_busy;
    logic [7:0] out_data;
    logic       out_write_enable;
    logic       out_first_block;
    logic       out_last_block;
    logic       msg_done;

    logic busy_auto;
    logic busy_hold;
    assign core_busy = busy_auto | busy_hold;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .core_busy        (core_busy),
        .out_data         (out_data),
        .out_write_enable (out_write_enable),
        .out_first_block  (out_first_block),
        .out_last_block   (out_last_block),
        .msg_done         (msg_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Core-side monitor / busy model
    logic [7:0] cap [0:255];
    logic       cap_first [0:3];
    logic       cap_last  [0:3];
    int         cap_pos   = 0;
    int         proto_err = 0;
    int         done_cnt  = 0;
    int         we_cycles = 0;
    int         busy_cnt  = 0;
    int         clr_gen   = 0;
    int         clr_seen  = 0;

    always @(negedge clk) begin
        if (clr_gen != clr_seen) begin
            clr_seen  = clr_gen;
            cap_pos   = 0;
            proto_err = 0;
            done_cnt  = 0;
            we_cycles = 0;
            busy_cnt  = 0;
            busy_auto = 1'b0;
            for (int b = 0; b < 4; b++) begin
                cap_first[b] = 1'b0;
                cap_last[b]  = 1'b0;
            end
        end else begin
            if (out_write_enable) begin
                if (cap_pos < 256) begin
                    cap[cap_pos] = out_data;
                    if (cap_pos % 64 == 0) begin
                        cap_first[cap_pos/64] = out_first_block;
                        cap_last[cap_pos/64]  = out_last_block;
                    end else if (out_first_block || out_last_block) begin
                        proto_err++;
                    end
                end
                we_cycles++;
                cap_pos++;
                if (cap_pos % 64 == 0) busy_cnt = 3;
            end else if (cap_pos % 64 != 0) begin
                proto_err++;
            end
            if (msg_done) done_cnt++;
            busy_auto = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         incr;
        int         nblk;
        int         p80_blk;
        int         p80_byte;
        logic [15:0] len16;
    } vec_t;

    vec_t vecs [0:7];

    task automatic clear_cap();
        clr_gen++;
        @(negedge clk);
        #1;
    endtask

    task automatic send_msg(input int len, input logic [7:0] base, input bit incr);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < len && guard < 5000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = base + (incr ? 8'(i) : 8'h00);
                in_last  = (i == len - 1);
                if (in_ready) i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("accepted_bytes", 64'(i), 64'(len));
        chk("in_ready_after_last", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt < 1 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("msg_done_seen", {63'd0, done_cnt >= 1}, 64'd1);
        repeat (5) @(negedge clk);
        #1;
    endtask

    task automatic verify(input int vi);
        vec_t       v;
        int         g;
        int         mism;
        logic [7:0] e;
        v = vecs[vi];
        chk($sformatf("v%0d_byte_count", vi), 64'(cap_pos), 64'(v.nblk * 64));
        chk($sformatf("v%0d_protocol", vi), 64'(proto_err), 64'd0);
        chk($sformatf("v%0d_done_count", vi), 64'(done_cnt), 64'd1);
        for (int b = 0; b < v.nblk; b++) begin
            mism = 0;
            for (int j = 0; j < 64; j++) begin
                g = b * 64 + j;
                if (g < v.len)                                e = v.base + (v.incr ? 8'(g) : 8'h00);
                else if (g == v.p80_blk * 64 + v.p80_byte)    e = 8'h80;
                else if (g == v.nblk * 64 - 2)                e = v.len16[15:8];
                else if (g == v.nblk * 64 - 1)                e = v.len16[7:0];
                else                                          e = 8'h00;
                if (cap[g] !== e) begin
                    if (mism == 0) $display("  v%0d blk%0d byte%0d got %02h exp %02h", vi, b, j, cap[g], e);
                    mism++;
                end
            end
            chk($sformatf("v%0d_blk%0d_bytes", vi, b), 64'(mism), 64'd0);
            chk($sformatf("v%0d_blk%0d_first", vi, b), {63'd0, cap_first[b]}, {63'd0, b == 0});
            chk($sformatf("v%0d_blk%0d_last", vi, b), {63'd0, cap_last[b]}, {63'd0, b == v.nblk - 1});
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{len: 3,   base: 8'h61, incr: 1'b1, nblk: 1, p80_blk: 0, p80_byte: 3,  len16: 16'h0018};
        vecs[1] = '{len: 55,  base: 8'h00, incr: 1'b0, nblk: 1, p80_blk: 0, p80_byte: 55, len16: 16'h01B8};
        vecs[2] = '{len: 56,  base: 8'hAA, incr: 1'b0, nblk: 2, p80_blk: 0, p80_byte: 56, len16: 16'h01C0};
        vecs[3] = '{len: 64,  base: 8'h00, incr: 1'b1, nblk: 2, p80_blk: 1, p80_byte: 0,  len16: 16'h0200};
        vecs[4] = '{len: 1,   base: 8'h5A, incr: 1'b0, nblk: 1, p80_blk: 0, p80_byte: 1,  len16: 16'h0008};
        vecs[5] = '{len: 63,  base: 8'h33, incr: 1'b1, nblk: 2, p80_blk: 0, p80_byte: 63, len16: 16'h01F8};
        vecs[6] = '{len: 120, base: 8'h10, incr: 1'b1, nblk: 3, p80_blk: 1, p80_byte: 56, len16: 16'h03C0};
        vecs[7] = '{len: 128, base: 8'hC3, incr: 1'b0, nblk: 3, p80_blk: 2, p80_byte: 0,  len16: 16'h0400};

        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        busy_hold = 1'b0;
        clr_gen   = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_we",       {63'd0, out_write_enable}, 64'd0);
        chk("reset_first",    {63'd0, out_first_block},  64'd0);
        chk("reset_last",     {63'd0, out_last_block},   64'd0);
        chk("reset_done",     {63'd0, msg_done},         64'd0);
        chk("reset_in_ready", {63'd0, in_ready},         64'd1);

        // Table-driven messages
        for (int v = 0; v < 8; v++) begin
            clear_cap();
            send_msg(vecs[v].len, vecs[v].base, vecs[v].incr);
            wait_done(3000);
            verify(v);
        end

        // Core held busy with a full buffer: nothing may be emitted
        clear_cap();
        busy_hold = 1'b1;
        send_msg(vecs[0].len, vecs[0].base, vecs[0].incr);
        repeat (80) @(negedge clk);
        #1;
        chk("hold_no_we",       64'(we_cycles), 64'd0);
        chk("hold_in_ready_lo", {63'd0, in_ready}, 64'd0);
        busy_hold = 1'b0;
        wait_done(3000);
        verify(0);

        // Reset in the middle of sending byte 30
        clear_cap();
        send_msg(vecs[0].len, vecs[0].base, vecs[0].incr);
        n = 0;
        while (cap_pos < 31 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_byte30", {63'd0, cap_pos >= 31}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_we",    {63'd0, out_write_enable}, 64'd0);
        chk("midrst_first", {63'd0, out_first_block},  64'd0);
        chk("midrst_last",  {63'd0, out_last_block},   64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_cap();
        send_msg(vecs[0].len, vecs[0].base, vecs[0].incr);
        wait_done(3000);
        verify(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
